// File: rtl/acum_mux_ctrl.sv
// Tap sequencer for the filter MAC datapath: shifts the delay line, walks the tap index and
// steers the accumulator input mux. All outputs are registered (Moore).
module acum_mux_ctrl #(
   parameter int unsigned N     = 25,
   parameter int unsigned TAPS  = 5,
   parameter int unsigned IDX_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_tick,
   input  logic             clr_err,
   output logic [1:0]       sel_mux,
   output logic [IDX_W-1:0] idx,
   output logic             shift_en,
   output logic             acc_en,
   output logic             busy,
   output logic             y_valid,
   output logic             overrun
);

   if (N == 0 || TAPS == 0 || TAPS > 2**IDX_W) begin : g_param_check
      $error("acum_mux_ctrl: illegal N/TAPS/IDX_W combination");
   end

   localparam logic [1:0]       sel_uk   = 2'b00;
   localparam logic [1:0]       sel_acum = 2'b01;
   localparam logic [1:0]       sel_zero = 2'b10;
   localparam logic [IDX_W-1:0] idx_last = IDX_W'(TAPS - 1);

   typedef enum logic [2:0] {
      s_idle,
      s_shift,
      s_first,
      s_accum,
      s_done
   } state_t;

   state_t state;

   logic in_seq;
   assign in_seq = (state == s_shift) || (state == s_first) || (state == s_accum);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= s_idle;
         sel_mux  <= sel_zero;
         idx      <= '0;
         shift_en <= 1'b0;
         acc_en   <= 1'b0;
         busy     <= 1'b0;
         y_valid  <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         shift_en <= 1'b0;
         y_valid  <= 1'b0;

         // A tick during an active sequence is dropped; setting beats clearing.
         if (sample_tick && in_seq) begin
            overrun <= 1'b1;
         end else if (clr_err) begin
            overrun <= 1'b0;
         end

         unique case (state)
            s_idle, s_done: begin
               idx     <= '0;
               sel_mux <= sel_zero;
               acc_en  <= 1'b0;
               if (sample_tick) begin
                  state    <= s_shift;
                  shift_en <= 1'b1;
                  busy     <= 1'b1;
               end else begin
                  state <= s_idle;
                  busy  <= 1'b0;
               end
            end

            s_shift: begin
               state   <= s_first;
               sel_mux <= sel_uk;
               acc_en  <= 1'b1;
               idx     <= '0;
               busy    <= 1'b1;
            end

            s_first: begin
               if (TAPS == 1) begin
                  state   <= s_done;
                  y_valid <= 1'b1;
                  sel_mux <= sel_zero;
                  acc_en  <= 1'b0;
                  busy    <= 1'b0;
                  idx     <= '0;
               end else begin
                  state   <= s_accum;
                  sel_mux <= sel_acum;
                  acc_en  <= 1'b1;
                  busy    <= 1'b1;
                  idx     <= IDX_W'(1);
               end
            end

            s_accum: begin
               if (idx == idx_last) begin
                  state   <= s_done;
                  y_valid <= 1'b1;
                  sel_mux <= sel_zero;
                  acc_en  <= 1'b0;
                  busy    <= 1'b0;
                  idx     <= '0;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end

            default: begin
               state   <= s_idle;
               sel_mux <= sel_zero;
               idx     <= '0;
               acc_en  <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_acum_mux_ctrl.sv
// Directed bench for acum_mux_ctrl: a TAPS=5 instance for the main scenarios and a TAPS=1
// instance for the single-tap sequence.
module tb_acum_mux_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sample_tick = 1'b0;
   logic       clr_err = 1'b0;

   logic [1:0] sel_mux;
   logic [2:0] idx;
   logic       shift_en, acc_en, busy, y_valid, overrun;

   logic [1:0] sel_mux1;
   logic [0:0] idx1;
   logic       shift_en1, acc_en1, busy1, y_valid1, overrun1;

   int total = 0;
   int bad = 0;

   logic [8:0] obs;
   logic [4:0] obs1;
   assign obs  = {sel_mux, idx, shift_en, acc_en, busy, y_valid};
   assign obs1 = {sel_mux1, shift_en1, acc_en1, busy1};

   always #5 clk = ~clk;

   acum_mux_ctrl #(.N(25), .TAPS(5), .IDX_W(3)) dut (
      .clk(clk), .reset(reset), .sample_tick(sample_tick), .clr_err(clr_err),
      .sel_mux(sel_mux), .idx(idx), .shift_en(shift_en), .acc_en(acc_en),
      .busy(busy), .y_valid(y_valid), .overrun(overrun)
   );

   acum_mux_ctrl #(.N(25), .TAPS(1), .IDX_W(1)) dut1 (
      .clk(clk), .reset(reset), .sample_tick(sample_tick), .clr_err(clr_err),
      .sel_mux(sel_mux1), .idx(idx1), .shift_en(shift_en1), .acc_en(acc_en1),
      .busy(busy1), .y_valid(y_valid1), .overrun(overrun1)
   );

   // Expected {sel,idx,shift_en,acc_en,busy,y_valid} j cycles after the tick edge (TAPS=5).
   function automatic logic [8:0] exp_seq(input int j);
      case (j)
         1:       return 9'b10_000_1010;
         2:       return 9'b00_000_0110;
         3:       return 9'b01_001_0110;
         4:       return 9'b01_010_0110;
         5:       return 9'b01_011_0110;
         6:       return 9'b01_100_0110;
         7:       return 9'b10_000_0001;
         default: return 9'b10_000_0000;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         total++;
         if ({obs, overrun} !== {9'b10_000_0000, 1'b0}) begin
            $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, {obs, overrun},
                     {9'b10_000_0000, 1'b0});
            bad++;
         end
      end
   endtask

   task automatic test_single();
      int acc_cnt = 0;
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         if (j > 1) step();
         if (acc_en === 1'b1) acc_cnt++;
         total++;
         if (obs !== exp_seq(j)) begin
            $display("FAIL single j=%0d got=%b want=%b", j, obs, exp_seq(j));
            bad++;
         end
      end
      total++;
      if (acc_cnt != 5) begin
         $display("FAIL acc_en_count got=%0d want=5", acc_cnt);
         bad++;
      end
   endtask

   task automatic test_back_to_back();
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      for (int j = 2; j <= 7; j++) step();
      // Now in DONE: a tick here starts the next sample without overrun.
      total++;
      if (obs !== exp_seq(7)) begin
         $display("FAIL b2b_done1 got=%b want=%b", obs, exp_seq(7));
         bad++;
      end
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         if (j > 1) step();
         total++;
         if ({obs, overrun} !== {exp_seq(j), 1'b0}) begin
            $display("FAIL b2b_second j=%0d got=%b want=%b", j, {obs, overrun},
                     {exp_seq(j), 1'b0});
            bad++;
         end
      end
   endtask

   task automatic test_overrun();
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      step();
      step();
      step();
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      for (int j = 5; j <= 8; j++) begin
         if (j > 5) step();
         total++;
         if ({obs, overrun} !== {exp_seq(j), 1'b1}) begin
            $display("FAIL overrun_seq j=%0d got=%b want=%b", j, {obs, overrun},
                     {exp_seq(j), 1'b1});
            bad++;
         end
      end
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      total++;
      if (overrun !== 1'b0) begin
         $display("FAIL overrun_clear got=%b want=0", overrun);
         bad++;
      end
      sample_tick = 1'b1;
      step();
      total++;
      if (overrun !== 1'b0) begin
         $display("FAIL overrun_idle_tick got=%b want=0", overrun);
         bad++;
      end
      step();
      total++;
      if (overrun !== 1'b1) begin
         $display("FAIL overrun_set got=%b want=1", overrun);
         bad++;
      end
      clr_err = 1'b1;
      step();
      sample_tick = 1'b0;
      total++;
      if ({obs, overrun} !== {exp_seq(3), 1'b1}) begin
         $display("FAIL overrun_set_wins got=%b want=%b", {obs, overrun}, {exp_seq(3), 1'b1});
         bad++;
      end
      step();
      clr_err = 1'b0;
      total++;
      if ({obs, overrun} !== {exp_seq(4), 1'b0}) begin
         $display("FAIL overrun_clear_busy got=%b want=%b", {obs, overrun}, {exp_seq(4), 1'b0});
         bad++;
      end
      repeat (4) step();
   endtask

   task automatic test_reset_mid();
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      sample_tick = 1'b1;
      step();
      reset = 1'b0;
      sample_tick = 1'b0;
      total++;
      if ({obs, overrun} !== {9'b10_000_0000, 1'b0}) begin
         $display("FAIL reset_mid got=%b want=%b", {obs, overrun}, {9'b10_000_0000, 1'b0});
         bad++;
      end
      for (int i = 0; i < 10; i++) begin
         step();
         total++;
         if ({y_valid, busy, shift_en} !== 3'b000) begin
            $display("FAIL reset_mid_quiet cyc=%0d got=%b want=000", i,
                     {y_valid, busy, shift_en});
            bad++;
         end
      end
   endtask

   task automatic test_taps1();
      logic [4:0] want [1:4];
      // {sel, shift_en, acc_en, busy} for SHIFT, FIRST, DONE, IDLE.
      want[1] = 5'b10_101;
      want[2] = 5'b00_011;
      want[3] = 5'b10_000;
      want[4] = 5'b10_000;
      repeat (2) step();
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      for (int j = 1; j <= 4; j++) begin
         if (j > 1) step();
         total++;
         if ({obs1, y_valid1, idx1} !== {want[j], (j == 3), 1'b0}) begin
            $display("FAIL taps1 j=%0d got=%b want=%b", j, {obs1, y_valid1, idx1},
                     {want[j], (j == 3), 1'b0});
            bad++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overrun();
      test_reset_mid();
      test_taps1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1);
   end

endmodule
